// File: rtl/sh7604_dbus_wbuf_pkg.sv
`default_nettype none
// ============================================================================
// sh7604_dbus_wbuf_pkg : shared types and the bufferable-address decode
// Revision 1.0
// ============================================================================
package sh7604_dbus_wbuf_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  ba;
    } WBUF_ENTRY_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } WbufState_t;

    // Only plain external-area writes may be posted.
    function automatic logic IsBufferable(input logic [31:0] a, input logic we, input logic lock);
        return (a[31:27] ==? 5'b00?00) && we && !lock;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sh7604_dbus_wbuf_if.sv
`default_nettype none
// ============================================================================
// sh7604_dbus_wbuf_if : request/response bus used on both the CBUS and DBUS side
// Revision 1.0
// ============================================================================
interface sh7604_dbus_wbuf_if;
    logic [31:0] a;
    logic [31:0] di;
    logic [3:0]  ba;
    logic        we;
    logic        req;
    logic        burst;
    logic        lock;
    logic [31:0] dout;
    logic        busy;

    modport master (output a, di, ba, we, req, burst, lock, input dout, busy);
    modport slave  (input a, di, ba, we, req, burst, lock, output dout, busy);
endinterface
`default_nettype wire

// File: rtl/sh7604_dbus_wbuf_fifo.sv
`default_nettype none
// ============================================================================
// sh7604_wbuf_fifo : posted-write queue, CE-gated, synchronous reset
// Revision 1.0
// ============================================================================
module sh7604_wbuf_fifo
    import sh7604_dbus_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        push_i,
    input  WBUF_ENTRY_t push_data_i,
    input  logic        pop_i,
    output logic        full_o,
    output logic        empty_o,
    output WBUF_ENTRY_t head_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    WBUF_ENTRY_t   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          w_push;
    logic          w_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (ce_i) begin
            if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ce_i && w_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule
`default_nettype wire

// File: rtl/sh7604_dbus_wbuf.sv
`default_nettype none
// ============================================================================
// sh7604_dbus_wbuf : posted-write buffer between CBUS and the BSC DBUS port
// Revision 1.0
// ============================================================================
module sh7604_dbus_wbuf
    import sh7604_dbus_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce_r_i,
    sh7604_dbus_wbuf_if.slave        cbus,
    sh7604_dbus_wbuf_if.master       dbus,
    output logic                     wb_empty_o
);
    WbufState_t  state_q;
    logic        src_fifo_q;
    logic        ack_q;
    logic [31:0] a_q;
    logic [31:0] di_q;
    logic [3:0]  ba_q;
    logic        we_q;
    logic        req_q;
    logic        burst_q;
    logic        lock_q;

    logic        w_bufferable;
    logic        w_push;
    logic        w_pop;
    logic        w_pt_pending;
    logic        w_full;
    logic        w_empty;
    WBUF_ENTRY_t w_head;
    WBUF_ENTRY_t w_push_data;

    assign w_bufferable = IsBufferable(cbus.a, cbus.we, cbus.lock);
    assign w_push       = cbus.req && w_bufferable && !w_full;
    assign w_pt_pending = cbus.req && !w_bufferable && !ack_q;
    assign w_pop        = (state_q == WAIT) && !dbus.busy && src_fifo_q;
    assign w_push_data  = '{a: cbus.a, d: cbus.di, ba: cbus.ba};

    // A pass-through request is released only by its own ACK cycle.
    assign cbus.busy  = cbus.req && (w_bufferable ? w_full : !ack_q);
    assign cbus.dout  = dbus.dout;
    assign wb_empty_o = w_empty && (state_q == IDLE);

    assign dbus.a     = a_q;
    assign dbus.di    = di_q;
    assign dbus.ba    = ba_q;
    assign dbus.we    = we_q;
    assign dbus.req   = req_q;
    assign dbus.burst = burst_q;
    assign dbus.lock  = lock_q;

    sh7604_wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .ce_i        (ce_r_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .head_o      (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            src_fifo_q <= 1'b0;
            ack_q      <= 1'b0;
            a_q        <= '0;
            di_q       <= '0;
            ba_q       <= '0;
            we_q       <= 1'b0;
            req_q      <= 1'b0;
            burst_q    <= 1'b0;
            lock_q     <= 1'b0;
        end else if (ce_r_i) begin
            ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!w_empty) begin
                        a_q        <= w_head.a;
                        di_q       <= w_head.d;
                        ba_q       <= w_head.ba;
                        we_q       <= 1'b1;
                        burst_q    <= 1'b0;
                        lock_q     <= 1'b0;
                        req_q      <= 1'b1;
                        src_fifo_q <= 1'b1;
                        state_q    <= LAUNCH;
                    end else if (w_pt_pending) begin
                        a_q        <= cbus.a;
                        di_q       <= cbus.di;
                        ba_q       <= cbus.ba;
                        we_q       <= cbus.we;
                        burst_q    <= cbus.burst;
                        lock_q     <= cbus.lock;
                        req_q      <= 1'b1;
                        src_fifo_q <= 1'b0;
                        state_q    <= LAUNCH;
                    end
                end
                // BSC is still registering BUSY on this edge.
                LAUNCH: state_q <= WAIT;
                WAIT: begin
                    if (!dbus.busy) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                        if (!src_fifo_q) ack_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
